mem_arbiter_rr: RTL and testbench
=================================

Name: mem_arbiter_rr

Overview:
- Parametrised N-port round-robin arbiter between cache miss/writeback ports and the single shared memory port.
- Successor to the fixed I-cache-read / D-cache-read / D-cache-write arbiter in the cpu top level.
- Adds a configurable port count and fair round-robin grant.
- Adds registered, stable memory-side outputs and an optional ack-timeout watchdog.

Parameters:
- N_PORTS, 3: number of requesting clients (2..8).
- WIDTH, `MEMORY_WIDTH (128): memory line width in bits.
- ADDR_W, 32: address width.
- TIMEOUT, 1024: cycles to wait for mem_ack before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req  in  N_PORTS  per-port transaction request, level.
- rw  in  N_PORTS  per-port direction: 1=read, 0=write.
- addr  in  N_PORTS*ADDR_W  flattened per-port address; port i at [i*ADDR_W +: ADDR_W].
- wdata  in  N_PORTS*WIDTH  flattened per-port write data.
- ack  out  N_PORTS  per-port one-cycle completion pulse.
- rdata  out  WIDTH  read data; valid in the ack cycle of a read.
- err  out  1  one-cycle timeout flag, coincident with ack (optional feature only).
- mem_enable  out  1  memory request, held until mem_ack.
- mem_rw  out  1  1=read, 0=write.
- mem_ack  in  1  memory completion.
- mem_addr  out  ADDR_W  memory address.
- mem_data_in  out  WIDTH  write data to memory.
- mem_data_out  in  WIDTH  read data from memory.

Behaviour:
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if any req is high, pick a winner, latch its index/rw/addr/wdata into output registers, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: mem_enable=1, memory-side outputs held constant. On a mem_ack sampled high, latch mem_data_out into rdata (reads only) and go to RESP.
  - RESP: ack[grant]=1 for exactly one cycle, mem_enable=0, return to IDLE.
- Latency: req high at edge t gives mem_enable at t+1. If mem_ack is high in the first ISSUE cycle, ack arrives at t+2. Minimum req-to-ack is 2 cycles; one idle cycle separates memory transactions.
- Round-robin:
  - Search starts at last_grant+1 and wraps modulo N_PORTS.
  - last_grant updates on each grant.
  - Reset value of last_grant is N_PORTS-1, so port 0 wins first.
  - A port waits at most N_PORTS-1 other transactions.
- Client rules:
  - Hold rw/addr/wdata stable while req is high.
  - Deassert req the cycle after ack unless a new transaction is intended. A req still high in IDLE is a new request.
- Boundary cases:
  - req dropped during ISSUE: the transaction still completes and ack is still pulsed; simulation assertion fires.
  - mem_ack outside ISSUE: ignored.
  - Writes leave rdata unchanged.
- Reset asserted at any time, including mid-transaction:
  - Asynchronously clears the FSM to IDLE.
  - Drives ack, err, mem_enable, mem_rw, mem_addr, mem_data_in, rdata to 0 and last_grant to N_PORTS-1.
  - The in-flight transaction is dropped without ack.
- mem_addr/mem_data_in/mem_rw are zeroed in IDLE.

Optional Feature:
- Macro MEM_ARBITER_TIMEOUT_EN.
- Defined: a counter clears on entry to ISSUE and increments each ISSUE cycle. If it reaches TIMEOUT without mem_ack:
  - mem_enable drops.
  - FSM goes to RESP with err=1 and ack[grant]=1; rdata is unchanged.
  - Round-robin advances as normal.
- Undefined: no counter, no err logic; err is tied to 0, and ISSUE waits indefinitely.

Decomposition:
- Shared package arb_pkg holds:
  - State encoding constants ARB_IDLE/ARB_ISSUE/ARB_RESP.
  - Index-width function (clog2 of N_PORTS).
  - RW_READ=1 / RW_WRITE=0.
- One combinational sub-module rr_picker:
  - Inputs: req vector and last_grant.
  - Outputs: winner index and any_req.
  - Separately testable.

Test Plan:
- Port 0 read, addr 0x100, mem_ack 2 cycles after mem_enable, mem_data_out=0xA5A5... -> mem_rw=1, mem_addr=0x100, single ack[0] pulse, rdata=0xA5A5... in ack cycle.
- Ports 0,1,2 all hold req from reset, mem_ack immediate -> grant order 0,1,2,0,1; one idle cycle between transactions.
- Port 2 write, addr 0x200, wdata=0x1234 -> mem_rw=0, mem_data_in=0x1234, ack[2] pulse, rdata unchanged.
- reset driven low during ISSUE -> all outputs 0 immediately; no ack for dropped transaction; after release with ports 1,2 requesting, port 1 granted first.
- MEM_ARBITER_TIMEOUT_EN, TIMEOUT=8, port 1 read, mem_ack never -> mem_enable high 8 cycles, then ack[1] and err=1 together. Without the macro: mem_enable stays high and err=0.
- Port 0 keeps req high after ack while port 1 is waiting -> port 1 granted next, then port 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin memory arbiter: FSM state encoding,
// read/write direction constants and the grant-index width helper.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 128
`endif

package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // A two-port arbiter still needs one index bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner selection: search starts one past the
// previous grant and wraps modulo N_PORTS.
module rr_picker
  import arb_pkg::*;
#(
  parameter int N_PORTS = 3,
  parameter int IDX_W   = idx_width(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  logic [IDX_W-1:0] cand;

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    winner  = '0;
    cand    = '0;
    any_req = |req;
    // Walk from the farthest offset down so the nearest requester is written last.
    for (int k = N_PORTS; k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant) + k) % N_PORTS);
      if (req[cand]) begin
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port round-robin arbiter in front of the single shared memory port, with
// registered memory-side outputs. Define MEM_ARBITER_TIMEOUT_EN to add the
// mem_ack watchdog that aborts a transaction with err after TIMEOUT cycles.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 128
`endif

module mem_arbiter_rr
  import arb_pkg::*;
#(
  parameter int N_PORTS = 3,
  parameter int WIDTH   = `MEMORY_WIDTH,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PORTS-1:0]          req,
  input  logic [N_PORTS-1:0]          rw,
  input  logic [N_PORTS*ADDR_W-1:0]   addr,
  input  logic [N_PORTS*WIDTH-1:0]    wdata,
  output logic [N_PORTS-1:0]          ack,
  output logic [WIDTH-1:0]            rdata,
  output logic                        err,
  output logic                        mem_enable,
  output logic                        mem_rw,
  input  logic                        mem_ack,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [WIDTH-1:0]            mem_data_in,
  input  logic [WIDTH-1:0]            mem_data_out
);

  localparam int                IDX_W    = idx_width(N_PORTS);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_PORTS - 1);

  if (N_PORTS < 2 || N_PORTS > 8 || TIMEOUT < 1) begin : g_param_check
    $error("mem_arbiter_rr: N_PORTS must be 2..8 and TIMEOUT at least 1");
  end

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    winner;
  logic                any_req;
  logic                timeout_hit;
  logic [N_PORTS-1:0]  ack_d;
  logic                en_d, rw_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [WIDTH-1:0]    wdata_d, rdata_d;

  rr_picker #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req),
    .last_grant (last_q),
    .winner     (winner),
    .any_req    (any_req)
  );

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Counter sits at zero outside ISSUE, so it starts clean on every entry.
  assign timeout_hit = (state_q == ARB_ISSUE) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else begin
      cnt_q <= (state_q == ARB_ISSUE) ? cnt_q + 1'b1 : '0;
      err   <= timeout_hit && !mem_ack;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack_d   = '0;
    en_d    = mem_enable;
    rw_d    = mem_rw;
    addr_d  = mem_addr;
    wdata_d = mem_data_in;
    rdata_d = rdata;

    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_d = winner;
          last_d  = winner;
          en_d    = 1'b1;
          rw_d    = rw[winner];
          addr_d  = addr[winner*ADDR_W +: ADDR_W];
          wdata_d = wdata[winner*WIDTH +: WIDTH];
          state_d = ARB_ISSUE;
        end else begin
          rw_d    = RW_WRITE;
          addr_d  = '0;
          wdata_d = '0;
        end
      end

      ARB_ISSUE: begin
        // A real mem_ack wins over a watchdog expiry in the same cycle.
        if (mem_ack || timeout_hit) begin
          en_d           = 1'b0;
          ack_d[grant_q] = 1'b1;
          if (mem_ack && mem_rw == RW_READ) begin
            rdata_d = mem_data_out;
          end
          state_d = ARB_RESP;
        end
      end

      ARB_RESP: begin
        rw_d    = RW_WRITE;
        addr_d  = '0;
        wdata_d = '0;
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      last_q      <= LAST_RST;
      ack         <= '0;
      mem_enable  <= 1'b0;
      mem_rw      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      rdata       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      ack         <= ack_d;
      mem_enable  <= en_d;
      mem_rw      <= rw_d;
      mem_addr    <= addr_d;
      mem_data_in <= wdata_d;
      rdata       <= rdata_d;
    end
  end

  // A client that drops req mid-transaction still gets its ack; flag it in simulation.
  a_req_held : assert property (@(posedge clk) disable iff (!reset)
                                (state_q == ARB_ISSUE) |-> req[grant_q])
    else $error("mem_arbiter_rr: granted port dropped req during ISSUE");

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench for mem_arbiter_rr: a scoreboard of expected memory
// issues and client responses, fed by scenario tasks and drained by a monitor.
`timescale 1ns/1ps

module tb_mem_arbiter_rr;

  localparam int N  = 3;
  localparam int W  = 128;
  localparam int AW = 32;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req, rw, ack;
  logic [N*AW-1:0]   addr;
  logic [N*W-1:0]    wdata;
  logic [W-1:0]      rdata, mem_data_in, mem_data_out;
  logic              err, mem_enable, mem_rw, mem_ack;
  logic [AW-1:0]     mem_addr;

  always #5 clk = ~clk;

  mem_arbiter_rr #(
    .N_PORTS (N),
    .WIDTH   (W),
    .ADDR_W  (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .req          (req),
    .rw           (rw),
    .addr         (addr),
    .wdata        (wdata),
    .ack          (ack),
    .rdata        (rdata),
    .err          (err),
    .mem_enable   (mem_enable),
    .mem_rw       (mem_rw),
    .mem_ack      (mem_ack),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  typedef struct {
    bit             rw;
    logic [AW-1:0]  addr;
    logic [W-1:0]   wdata;
  } iss_t;

  typedef struct {
    int             port;
    bit             rd;
    logic [W-1:0]   data;
    bit             err;
  } resp_t;

  iss_t   iss_q[$];
  resp_t  resp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     ack_delay = 0;
  int     en_cnt = 0;
  bit     stray_ack = 1'b0;
  bit     gap_chk = 1'b0;
  int     rem[N];
  logic [W-1:0] rd_base = '0;
  logic [W-1:0] model_rdata = '0;

  // Monitor state
  logic          prev_en = 1'b0;
  int            last_ack_cyc = -1;
  int            last_rise_cyc = -1;
  iss_t          cur_iss;
  resp_t         cur_resp;
  logic [N-1:0]  exp_ack;
  logic [W-1:0]  exp_rd;
  logic          held_rw;
  logic [AW-1:0] held_addr;
  logic [W-1:0]  held_wd;

  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] mdata(input logic [AW-1:0] a);
    return rd_base ^ W'(a);
  endfunction

  // Memory responder and client req-release model.
  initial begin
    mem_ack = 1'b0;
    mem_data_out = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (ack[i] && rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) req[i] = 1'b0;
        end
      end
      if (mem_enable) en_cnt++;
      else en_cnt = 0;
      mem_ack = (mem_enable && ack_delay >= 0 && en_cnt == ack_delay + 1) ||
                (!mem_enable && stray_ack);
      mem_data_out = mdata(mem_addr);
      if (!(mem_ack && mem_enable)) mem_data_out = ~mem_data_out;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_enable === 1'b1 && prev_en === 1'b0) begin
        last_rise_cyc = cyc;
        checks++;
        if (iss_q.size() == 0) begin
          failures++;
          $display("FAIL issue: unexpected mem_enable at cycle %0d, addr=%h", cyc, mem_addr);
        end else begin
          cur_iss = iss_q.pop_front();
          if (mem_rw !== cur_iss.rw || mem_addr !== cur_iss.addr ||
              (cur_iss.rw == 1'b0 && mem_data_in !== cur_iss.wdata)) begin
            failures++;
            $display("FAIL issue: got rw=%b addr=%h data=%h, expected rw=%b addr=%h data=%h",
                     mem_rw, mem_addr, mem_data_in, cur_iss.rw, cur_iss.addr, cur_iss.wdata);
          end
          if (gap_chk && last_ack_cyc >= 0) begin
            checks++;
            if (cyc - last_ack_cyc !== 2) begin
              failures++;
              $display("FAIL idle_gap: ack-to-next-issue %0d cycles, expected 2", cyc - last_ack_cyc);
            end
          end
        end
        held_rw   = mem_rw;
        held_addr = mem_addr;
        held_wd   = mem_data_in;
      end else if (mem_enable === 1'b1) begin
        checks++;
        if (mem_rw !== held_rw || mem_addr !== held_addr || mem_data_in !== held_wd) begin
          failures++;
          $display("FAIL hold: mem side changed to rw=%b addr=%h, expected rw=%b addr=%h",
                   mem_rw, mem_addr, held_rw, held_addr);
        end
      end

      if (ack !== '0) begin
        last_ack_cyc = cyc;
        checks++;
        if (resp_q.size() == 0) begin
          failures++;
          $display("FAIL resp: unexpected ack=%b at cycle %0d, expected none", ack, cyc);
        end else begin
          cur_resp = resp_q.pop_front();
          exp_ack  = N'(1) << cur_resp.port;
          exp_rd   = cur_resp.rd ? cur_resp.data : model_rdata;
          if (ack !== exp_ack || rdata !== exp_rd || err !== cur_resp.err || mem_enable !== 1'b0) begin
            failures++;
            $display("FAIL resp: got ack=%b rdata=%h err=%b en=%b, expected ack=%b rdata=%h err=%b en=0",
                     ack, rdata, err, mem_enable, exp_ack, exp_rd, cur_resp.err);
          end
          model_rdata = exp_rd;
        end
      end
      prev_en = mem_enable;
    end else begin
      prev_en = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input bit r, input logic [AW-1:0] a,
                          input logic [W-1:0] wd, input int n);
    rw[p] = r;
    addr[p*AW +: AW] = a;
    wdata[p*W +: W] = wd;
    rem[p] = n;
  endtask

  task automatic push_txn(input int p, input bit r, input logic [AW-1:0] a,
                          input logic [W-1:0] wd, input bit with_resp, input bit e);
    iss_q.push_back('{rw: r, addr: a, wdata: wd});
    if (with_resp) resp_q.push_back('{port: p, rd: (r && !e), data: mdata(a), err: e});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((iss_q.size() != 0 || resp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (iss_q.size() != 0 || resp_q.size() != 0) begin
      failures++;
      $display("FAIL %s drain: %0d issues and %0d responses pending after %0d cycles, expected 0",
               name, iss_q.size(), resp_q.size(), budget);
      iss_q.delete();
      resp_q.delete();
    end
    step(1);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    req = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    model_rdata = '0;
    last_ack_cyc = -1;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0; rw = '0; addr = '0; wdata = '0;
    step(3);
    @(negedge clk);
    checks++;
    if (ack !== '0 || err !== 1'b0 || mem_enable !== 1'b0 || mem_rw !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ack=%b err=%b en=%b rw=%b, expected all 0", ack, err, mem_enable, mem_rw);
    end
    checks++;
    if (mem_addr !== '0 || mem_data_in !== '0 || rdata !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wd=%h rdata=%h, expected 0", mem_addr, mem_data_in, rdata);
    end
    step(1);
    rst_n = 1'b1;
    model_rdata = '0;
    step(2);
  endtask

  task automatic test_read();
    int req_cyc;
    ack_delay = 2;
    rd_base = {16{8'hA5}};
    set_port(0, 1'b1, 32'h100, '0, 1);
    push_txn(0, 1'b1, 32'h100, '0, 1'b1, 1'b0);
    req_cyc = cyc;
    req[0] = 1'b1;
    wait_drain("read", 20);
    checks++;
    if (last_rise_cyc - req_cyc !== 1) begin
      failures++;
      $display("FAIL read_latency_en: %0d cycles, expected 1", last_rise_cyc - req_cyc);
    end
    checks++;
    if (last_ack_cyc - req_cyc !== 4) begin
      failures++;
      $display("FAIL read_latency_ack: %0d cycles, expected 4", last_ack_cyc - req_cyc);
    end
  endtask

  task automatic test_rr_all();
    rst_n = 1'b0;
    step(1);
    ack_delay = 0;
    rd_base = {4{32'hC0DE_0000}};
    model_rdata = '0;
    last_ack_cyc = -1;
    set_port(0, 1'b1, 32'h1000, '0, 2);
    set_port(1, 1'b1, 32'h1010, '0, 2);
    set_port(2, 1'b1, 32'h1020, '0, 1);
    push_txn(0, 1'b1, 32'h1000, '0, 1'b1, 1'b0);
    push_txn(1, 1'b1, 32'h1010, '0, 1'b1, 1'b0);
    push_txn(2, 1'b1, 32'h1020, '0, 1'b1, 1'b0);
    push_txn(0, 1'b1, 32'h1000, '0, 1'b1, 1'b0);
    push_txn(1, 1'b1, 32'h1010, '0, 1'b1, 1'b0);
    req = 3'b111;
    gap_chk = 1'b1;
    step(1);
    rst_n = 1'b1;
    wait_drain("rr_all", 60);
    gap_chk = 1'b0;
  endtask

  task automatic test_write();
    int bad = 0;
    // mem_ack while idle must not produce an ack or touch rdata
    stray_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack !== '0 || mem_enable !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stray_ack: %0d idle cycles reacted to mem_ack, expected 0", bad);
    end
    step(1);
    stray_ack = 1'b0;
    step(1);
    ack_delay = 1;
    set_port(2, 1'b0, 32'h200, W'(32'h1234), 1);
    push_txn(2, 1'b0, 32'h200, W'(32'h1234), 1'b1, 1'b0);
    req[2] = 1'b1;
    wait_drain("write", 20);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    reset_pulse();
    ack_delay = -1;
    set_port(0, 1'b1, 32'h300, '0, 1);
    push_txn(0, 1'b1, 32'h300, '0, 1'b0, 1'b0);
    req[0] = 1'b1;
    while (mem_enable !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_enable !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_issue: mem_enable=%b, expected 1", mem_enable);
    end
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== '0 || err !== 1'b0 || mem_enable !== 1'b0 || mem_rw !== 1'b0 ||
        mem_addr !== '0 || mem_data_in !== '0 || rdata !== '0) begin
      failures++;
      $display("FAIL reset_mid_clear: ack=%b en=%b rw=%b addr=%h rdata=%h, expected 0",
               ack, mem_enable, mem_rw, mem_addr, rdata);
    end
    req = '0;
    rem[0] = 0;
    iss_q.delete();
    model_rdata = '0;
    ack_delay = 0;
    set_port(1, 1'b0, 32'h310, W'(32'h5555), 1);
    set_port(2, 1'b1, 32'h320, '0, 1);
    push_txn(1, 1'b0, 32'h310, W'(32'h5555), 1'b1, 1'b0);
    push_txn(2, 1'b1, 32'h320, '0, 1'b1, 1'b0);
    req[1] = 1'b1;
    req[2] = 1'b1;
    step(1);
    rst_n = 1'b1;
    wait_drain("reset_mid", 30);
  endtask

  task automatic test_timeout();
    int en_seen = 0;
    int bad = 0;
    reset_pulse();
    ack_delay = 0;
    rd_base = {4{32'h0BAD_F00D}};
    set_port(1, 1'b1, 32'h400, '0, 1);
    push_txn(1, 1'b1, 32'h400, '0, 1'b1, 1'b0);
    req[1] = 1'b1;
    wait_drain("timeout_prime", 20);
    ack_delay = -1;
    set_port(1, 1'b1, 32'h404, '0, 1);
`ifdef MEM_ARBITER_TIMEOUT_EN
    push_txn(1, 1'b1, 32'h404, '0, 1'b1, 1'b1);
    req[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack !== '0) break;
      if (mem_enable === 1'b1) en_seen++;
    end
    checks++;
    if (en_seen !== TO) begin
      failures++;
      $display("FAIL timeout_len: mem_enable high %0d cycles, expected %0d", en_seen, TO);
    end
    wait_drain("timeout", 10);
`else
    push_txn(1, 1'b1, 32'h404, '0, 1'b0, 1'b0);
    req[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_enable === 1'b1) en_seen++;
      if (ack !== '0 || err !== 1'b0) bad++;
    end
    checks++;
    if (en_seen !== 39 || bad !== 0) begin
      failures++;
      $display("FAIL no_timeout: enable cycles %0d, ack/err cycles %0d, expected 39 and 0", en_seen, bad);
    end
    wait_drain("no_timeout", 5);
    reset_pulse();
`endif
  endtask

  task automatic test_fairness();
    reset_pulse();
    ack_delay = 3;
    rd_base = {4{32'hFA11_0000}};
    set_port(0, 1'b1, 32'h500, '0, 2);
    set_port(1, 1'b1, 32'h510, '0, 1);
    push_txn(0, 1'b1, 32'h500, '0, 1'b1, 1'b0);
    push_txn(1, 1'b1, 32'h510, '0, 1'b1, 1'b0);
    push_txn(0, 1'b1, 32'h500, '0, 1'b1, 1'b0);
    req[0] = 1'b1;
    step(2);
    req[1] = 1'b1;
    wait_drain("fairness", 40);
    step(5);
  endtask

  initial begin
    req = '0;
    test_reset();
    test_read();
    test_rr_all();
    test_write();
    test_reset_mid();
    test_timeout();
    test_fairness();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
